// File: rtl/trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// trace_buffer_pkg
//   Shared definitions for the instruction trace buffer:
//   - field widths of one trace entry (PC, IR, ALU value)
//   - the two-state mode enum (CAPTURE / FROZEN)
//   - the ControlUnit decode-state encoding used as the default capture trigger
//   - entry_t packed struct and a helper that assembles an entry
// -----------------------------------------------------------------------------
package trace_buffer_pkg;

  localparam int PC_W    = 8;
  localparam int IR_W    = 16;
  localparam int ALU_W   = 16;
  localparam int STATE_W = 8;
  localparam int ENTRY_W = PC_W + IR_W + ALU_W;

  // ControlUnit encoding of the decode state; entering it marks a new instruction.
  localparam logic [STATE_W-1:0] CU_STATE_DECODE = 8'h01;

  typedef enum logic [0:0] {
    MODE_CAPTURE = 1'b0,
    MODE_FROZEN  = 1'b1
  } mode_e;

  // Field order matches the 40-bit entry layout {PC, IR, ALU}.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IR_W-1:0]  ir;
    logic [ALU_W-1:0] alu;
  } entry_t;

  function automatic entry_t make_entry(
    input logic [PC_W-1:0]  pc,
    input logic [IR_W-1:0]  ir,
    input logic [ALU_W-1:0] alu
  );
    entry_t e;
    e.pc  = pc;
    e.ir  = ir;
    e.alu = alu;
    return e;
  endfunction

endpackage

// File: rtl/trace_buffer_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
//   DEPTH x 40-bit simple dual-port RAM holding the trace entries.
//   Ports:
//     clk      - system clock
//     reset    - synchronous active-high reset (clears the read register only)
//     wr_en    - write strobe, wr_data stored at wr_addr on the rising edge
//     wr_addr  - write address
//     wr_data  - entry to store
//     rd_en    - read strobe; when low the read register is forced to zero so
//                the trace outputs read as zero outside an active readout
//     rd_addr  - read address
//     rd_data  - registered read data (1-cycle latency)
//   The storage array itself is never reset; only entries written since the
//   last clear are ever read back.
// -----------------------------------------------------------------------------
module trace_ram
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem_r [DEPTH];
  entry_t rd_data_r;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; zero when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= entry_t'({ENTRY_W{1'b0}});
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= entry_t'({ENTRY_W{1'b0}});
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
//   Records one {PC, IR, ALU} entry per executed instruction (each entry into
//   CAPTURE_STATE) into a circular buffer. A Freeze pulse stops recording; the
//   buffer can then be stepped through oldest-to-newest for display/debug.
//   Arm clears the buffer and resumes recording. Never drives the processor.
//   Ports:
//     Clk, Reset          - clock, synchronous active-high reset
//     State               - processor current state
//     PC_In, IR_In, ALU_In- processor debug outputs sampled on a capture
//     Freeze, Arm         - one-cycle pulses: stop capture / clear and resume
//     Rd_Next, Rd_Rewind  - one-cycle pulses: step / return to oldest entry
//     Trace_PC/IR/ALU     - entry at the read pointer (1-cycle read latency)
//     Rd_Valid            - Trace_* hold a valid entry
//     Count               - number of valid entries (0..DEPTH)
//     Wrapped             - at least one entry has been overwritten
//     Capturing           - block is in CAPTURE mode
// -----------------------------------------------------------------------------
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int                 DEPTH         = 16,
  parameter int                 AW            = 4,
  parameter logic [STATE_W-1:0] CAPTURE_STATE = CU_STATE_DECODE,
  parameter bit                 STOP_ON_FULL  = 1'b0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [STATE_W-1:0] State,
  input  logic [PC_W-1:0]    PC_In,
  input  logic [IR_W-1:0]    IR_In,
  input  logic [ALU_W-1:0]   ALU_In,
  input  logic               Freeze,
  input  logic               Arm,
  input  logic               Rd_Next,
  input  logic               Rd_Rewind,
  output logic [PC_W-1:0]    Trace_PC,
  output logic [IR_W-1:0]    Trace_IR,
  output logic [ALU_W-1:0]   Trace_ALU,
  output logic               Rd_Valid,
  output logic [AW:0]        Count,
  output logic               Wrapped,
  output logic               Capturing
);

  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  mode_e              mode_r;
  mode_e              mode_nxt_s;

  logic [STATE_W-1:0] prev_state_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               wrapped_r;
  logic               capturing_r;
  logic               rd_valid_r;

  logic               capture_event_s;
  logic               wr_en_s;
  logic               clear_s;
  logic               rd_en_s;
  logic               enter_frozen_s;

  logic [AW-1:0]      base_wr_ptr_s;
  logic [AW:0]        base_count_s;
  logic               base_wrapped_s;
  logic               full_s;
  logic [AW-1:0]      wr_ptr_nxt_s;
  logic [AW:0]        count_nxt_s;
  logic               wrapped_nxt_s;

  logic [AW-1:0]      oldest_cur_s;
  logic [AW-1:0]      oldest_nxt_s;
  logic [AW-1:0]      newest_s;
  logic [AW-1:0]      rd_ptr_nxt_s;

  entry_t             wr_entry_s;
  entry_t             rd_entry_s;

  // Rising-edge detect on the decode state: one capture per entry, however
  // long the processor dwells there.
  assign capture_event_s = (State == CAPTURE_STATE) && (prev_state_r != CAPTURE_STATE);

  assign wr_entry_s = make_entry(PC_In, IR_In, ALU_In);

  // Mode state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_r <= MODE_CAPTURE;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Mode next-state logic. A write that fills the buffer freezes it when
  // STOP_ON_FULL is set; the write itself still completes.
  always_comb begin
    mode_nxt_s = mode_r;
    case (mode_r)
      MODE_CAPTURE: begin
        if (Freeze) begin
          mode_nxt_s = MODE_FROZEN;
        end else if (STOP_ON_FULL && wr_en_s && (count_nxt_s == CNT_FULL)) begin
          mode_nxt_s = MODE_FROZEN;
        end else begin
          mode_nxt_s = MODE_CAPTURE;
        end
      end
      MODE_FROZEN: begin
        if (Arm) begin
          mode_nxt_s = MODE_CAPTURE;
        end else begin
          mode_nxt_s = MODE_FROZEN;
        end
      end
      default: begin
        mode_nxt_s = MODE_CAPTURE;
      end
    endcase
  end

  // Mode output decode: write, clear and read strobes.
  always_comb begin
    wr_en_s = 1'b0;
    clear_s = 1'b0;
    rd_en_s = 1'b0;
    case (mode_r)
      MODE_CAPTURE: begin
        clear_s = Arm;
        wr_en_s = capture_event_s;
        rd_en_s = 1'b0;
      end
      MODE_FROZEN: begin
        clear_s = Arm;
        wr_en_s = 1'b0;
        // Read only while staying frozen with data present, so Trace_* fall
        // to zero on the edge that re-arms.
        rd_en_s = !Arm && (count_r != CNT_ZERO);
      end
      default: begin
        clear_s = 1'b1;
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
      end
    endcase
  end

  assign enter_frozen_s = (mode_r == MODE_CAPTURE) && (mode_nxt_s == MODE_FROZEN);

  // Write pointer / count / wrap next values. Arm clears first, so a capture
  // in the same cycle lands at address 0 with a count of one.
  always_comb begin
    base_wr_ptr_s  = clear_s ? PTR_ZERO : wr_ptr_r;
    base_count_s   = clear_s ? CNT_ZERO : count_r;
    base_wrapped_s = clear_s ? 1'b0     : wrapped_r;
    full_s         = (base_count_s == CNT_FULL);
    if (wr_en_s) begin
      wr_ptr_nxt_s  = base_wr_ptr_s + PTR_ONE;
      count_nxt_s   = full_s ? CNT_FULL : (base_count_s + CNT_ONE);
      wrapped_nxt_s = base_wrapped_s | full_s;
    end else begin
      wr_ptr_nxt_s  = base_wr_ptr_s;
      count_nxt_s   = base_count_s;
      wrapped_nxt_s = base_wrapped_s;
    end
  end

  // Read pointer next value. On freeze entry the oldest entry is computed from
  // post-write values so a capture in the freeze cycle is included.
  always_comb begin
    oldest_cur_s = wrapped_r ? wr_ptr_r : PTR_ZERO;
    oldest_nxt_s = wrapped_nxt_s ? wr_ptr_nxt_s : PTR_ZERO;
    newest_s     = wr_ptr_r - PTR_ONE;
    if (enter_frozen_s) begin
      rd_ptr_nxt_s = oldest_nxt_s;
    end else if (clear_s) begin
      rd_ptr_nxt_s = PTR_ZERO;
    end else if ((mode_r == MODE_FROZEN) && Rd_Rewind) begin
      rd_ptr_nxt_s = oldest_cur_s;
    end else if ((mode_r == MODE_FROZEN) && Rd_Next && (count_r != CNT_ZERO) &&
                 (rd_ptr_r != newest_s)) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Pointer, counter and status registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_state_r <= ~CAPTURE_STATE;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      wrapped_r    <= 1'b0;
      capturing_r  <= 1'b1;
      rd_valid_r   <= 1'b0;
    end else begin
      prev_state_r <= State;
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      wrapped_r    <= wrapped_nxt_s;
      capturing_r  <= (mode_nxt_s == MODE_CAPTURE);
      // Tracks the read register: valid exactly when a read was issued.
      rd_valid_r   <= rd_en_s;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_trace_ram (
    .clk     (Clk),
    .reset   (Reset),
    .wr_en   (wr_en_s),
    .wr_addr (base_wr_ptr_s),
    .wr_data (wr_entry_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_entry_s)
  );

  assign Trace_PC  = rd_entry_s.pc;
  assign Trace_IR  = rd_entry_s.ir;
  assign Trace_ALU = rd_entry_s.alu;
  assign Rd_Valid  = rd_valid_r;
  assign Count     = count_r;
  assign Wrapped   = wrapped_r;
  assign Capturing = capturing_r;

endmodule
